byte_dispatch_controller: RTL and testbench

- Upstream stage of the 8-bit 1-to-4 demux.
- Accepts a byte stream on a valid/ready handshake and buffers it in a small FIFO.
- Assigns each byte a destination lane round-robin, skipping lanes that are not ready.
- Drives the demux data input `a` and select `s`, plus a one-hot write strobe. Consumers need the strobe because the demux drives 0 on unselected lanes, which is not a valid qualifier.

---
 rtl/byte_dispatch_controller_pkg.sv | 19 +
 rtl/byte_dispatch_controller_fifo.sv | 63 ++++++
 rtl/byte_dispatch_controller.sv | 72 +++++++
 tb/tb_byte_dispatch_controller.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/byte_dispatch_controller_pkg.sv
// Shared definitions for the byte dispatcher and the downstream 1-to-4 demux.
// Holds the lane geometry, the per-cycle action encoding and the one-hot select decode.
package byte_dispatch_controller_pkg;

    localparam int unsigned LANES = 4;
    localparam int unsigned SEL_W = 2;

    typedef enum logic [1:0] {
        ACT_IDLE,
        ACT_DISPATCH,
        ACT_SKIP,
        ACT_FLUSH
    } action_e;

    function automatic logic [LANES-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
        return LANES'(1) << sel;
    endfunction

endpackage

// File: rtl/byte_dispatch_controller_fifo.sv
// Synchronous FIFO with asynchronous reset that also clears the storage array.
// Full and empty are derived from the occupancy count; pointers wrap modulo DEPTH.
module byte_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            // storage is deliberately left intact; only the bookkeeping clears
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= din;
                wptr      <= wptr + AW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/byte_dispatch_controller.sv
// Buffers a byte stream and hands each byte to the next ready demux lane round-robin.
// Lanes that are not ready are skipped at a cost of one cycle each.
module byte_dispatch_controller
    import byte_dispatch_controller_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     in_ready,
    input  logic [LANES-1:0]         lane_ready,
    output logic [WIDTH-1:0]         a,
    output logic [SEL_W-1:0]         s,
    output logic                     out_valid,
    output logic [LANES-1:0]         lane_we,
    output logic [$clog2(DEPTH):0]   count
);

    logic    full;
    logic    empty;
    logic    push;
    action_e act;

    assign in_ready  = !full && !flush;
    assign push      = in_valid && in_ready;
    assign out_valid = !empty;

    always_comb begin
        act = ACT_IDLE;
        if (flush) begin
            act = ACT_FLUSH;
        end else if (out_valid) begin
            act = lane_ready[s] ? ACT_DISPATCH : ACT_SKIP;
        end
    end

    assign lane_we = (act == ACT_DISPATCH) ? sel_onehot(s) : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s <= '0;
        end else begin
            case (act)
                ACT_FLUSH:    s <= '0;
                ACT_DISPATCH,
                ACT_SKIP:     s <= s + SEL_W'(1);
                default:      s <= s;
            endcase
        end
    end

    byte_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (act == ACT_DISPATCH),
        .flush (flush),
        .din   (in_data),
        .dout  (a),
        .count (count),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_byte_dispatch_controller.sv
// Directed bench for byte_dispatch_controller with hand-computed expectations.
module tb_byte_dispatch_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       flush;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic [3:0] lane_ready;
    logic [7:0] a;
    logic [1:0] s;
    logic       out_valid;
    logic [3:0] lane_we;
    logic [2:0] count;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_b;

    always #5 clk = ~clk;

    byte_dispatch_controller #(
        .DEPTH (4),
        .WIDTH (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .lane_ready (lane_ready),
        .a          (a),
        .s          (s),
        .out_valid  (out_valid),
        .lane_we    (lane_we),
        .count      (count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        flush      = 1'b0;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        lane_ready = 4'b0000;
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_s", 32'(s), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        tick();

        // Streaming: one byte per cycle to lanes 0..3
        lane_ready = 4'b1111;
        in_valid   = 1'b1;
        in_data    = 8'h11;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("stream_a", 32'(a), 32'(8'h11 * (i + 1)));
            chk("stream_s", 32'(s), 32'(i));
            chk("stream_we", 32'(lane_we), 32'(4'b0001 << i));
            chk("stream_count", 32'(count), 32'd1);
            if (i < 3) in_data = 8'(8'h11 * (i + 2));
            else       in_valid = 1'b0;
            tick();
        end
        chk("stream_end_count", 32'(count), 32'd0);
        chk("stream_end_valid", 32'(out_valid), 32'd0);
        chk("stream_end_s", 32'(s), 32'd0);

        // Full: no lane ready, offer five bytes
        lane_ready = 4'b0000;
        in_valid   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 8'(8'hA0 + i);
            tick();
            chk("full_count", 32'(count), 32'(i + 1));
            chk("full_s", 32'(s), 32'(i));
            chk("full_we", 32'(lane_we), 32'd0);
            chk("full_in_ready", 32'(in_ready), 32'(i < 3));
        end
        in_data = 8'hA4;
        tick();
        chk("full_hold_count", 32'(count), 32'd4);
        chk("full_hold_s", 32'(s), 32'd0);
        chk("full_hold_ready", 32'(in_ready), 32'd0);
        chk("full_head", 32'(a), 32'hA0);
        in_valid = 1'b0;

        // Skip: advance s to 2, then lane 2 not ready
        tick();
        tick();
        chk("skip_s2", 32'(s), 32'd2);
        lane_ready = 4'b1011;
        #1;
        chk("skip_we0", 32'(lane_we), 32'd0);
        tick();
        chk("skip_s3", 32'(s), 32'd3);
        chk("skip_we3", 32'(lane_we), 32'b1000);
        chk("skip_a", 32'(a), 32'hA0);
        tick();
        chk("skip_s0", 32'(s), 32'd0);
        chk("skip_count", 32'(count), 32'd3);
        chk("skip_next_a", 32'(a), 32'hA1);

        // Flush with count 3 and a byte on offer
        lane_ready = 4'b1111;
        in_valid   = 1'b1;
        in_data    = 8'h55;
        flush      = 1'b1;
        #1;
        chk("flush_in_ready", 32'(in_ready), 32'd0);
        chk("flush_we", 32'(lane_we), 32'd0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_s", 32'(s), 32'd0);
        chk("flush_valid", 32'(out_valid), 32'd0);

        // Push/pop at the full boundary, ordering tracked by a queue
        lane_ready = 4'b0000;
        in_valid   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 8'(8'hB0 + i);
            exp_q.push_back(in_data);
            tick();
        end
        chk("bnd_count4", 32'(count), 32'd4);
        chk("bnd_s3", 32'(s), 32'd3);
        lane_ready = 4'b1111;
        in_data    = 8'hB4;
        #1;
        chk("bnd_no_ready", 32'(in_ready), 32'd0);
        chk("bnd_we_first", 32'(lane_we), 32'b1000);
        exp_b = exp_q.pop_front();
        chk("bnd_a_first", 32'(a), 32'(exp_b));
        tick();
        chk("bnd_count3", 32'(count), 32'd3);
        chk("bnd_ready_again", 32'(in_ready), 32'd1);
        exp_q.push_back(8'hB4);
        exp_b = exp_q.pop_front();
        chk("bnd_a_pushpop", 32'(a), 32'(exp_b));
        tick();
        in_valid = 1'b0;
        chk("bnd_count_stay", 32'(count), 32'd3);
        for (int i = 0; i < 3; i++) begin
            chk("bnd_drain_we", 32'(lane_we), 32'(4'b0001 << s));
            exp_b = exp_q.pop_front();
            chk("bnd_drain_a", 32'(a), 32'(exp_b));
            tick();
        end
        chk("bnd_empty", 32'(count), 32'd0);

        // Reset asserted mid-cycle while a dispatch is in progress
        lane_ready = 4'b0000;
        in_valid   = 1'b1;
        in_data    = 8'hC0;
        tick();
        in_data = 8'hC1;
        tick();
        in_valid   = 1'b0;
        lane_ready = 4'b1111;
        #1;
        chk("pre_rst_we_active", 32'(lane_we != 4'b0000), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("mid_rst_a", 32'(a), 32'h00);
        chk("mid_rst_s", 32'(s), 32'd0);
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_we", 32'(lane_we), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        #3;
        reset = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
